// File: rtl/rds_block_sync.sv
// RDS receive block synchroniser: finds 26-bit block boundaries from checkword/offset
// syndromes, flywheels through bad blocks, and assembles A-B-C-D groups.
module rds_block_sync #(
  parameter int c_max_bad = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic [15:0] block_data,
  output logic [2:0]  block_id,
  output logic        block_valid,
  output logic [63:0] group_data,
  output logic        group_valid,
  output logic        synced,
  output logic [3:0]  bad_count
);

  localparam logic [9:0] OFS_A  = 10'h0FC;
  localparam logic [9:0] OFS_B  = 10'h198;
  localparam logic [9:0] OFS_C  = 10'h168;
  localparam logic [9:0] OFS_CP = 10'h350;
  localparam logic [9:0] OFS_D  = 10'h1B4;

  typedef enum logic [1:0] {SEARCH, CONFIRM, SYNC} state_t;

  function automatic logic [9:0] crc10(input logic [15:0] m);
    logic [9:0] r;
    logic       fb;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      fb = m[i] ^ r[9];
      r  = {r[8:0], 1'b0};
      if (fb) r = r ^ 10'h1B9;
    end
    return r;
  endfunction

  // Offset code (0=A,1=B,2=C,3=C',4=D) to group slot (A,B,C,D = 0..3).
  function automatic logic [1:0] id_to_slot(input logic [2:0] id);
    return (id == 3'd4) ? 2'd3 : (id == 3'd3) ? 2'd2 : id[1:0];
  endfunction

  state_t            state_reg, state_next;
  logic [25:0]       sr_reg, sr_next;
  logic [4:0]        bitpos_reg, bitpos_next;
  logic [2:0]        cand_id_reg, cand_id_next;
  logic [15:0]       cand_data_reg, cand_data_next;
  logic [1:0]        exp_slot_reg, exp_slot_next;
  logic [3:0]        bad_count_reg, bad_count_next;
  logic [3:0]        flags_reg, flags_next;
  logic [3:0][15:0]  slot_reg, slot_next;
  logic              pend_valid_reg, pend_valid_next;
  logic [2:0]        pend_id_reg, pend_id_next;
  logic [15:0]       pend_data_reg, pend_data_next;
  logic [15:0]       block_data_reg, block_data_next;
  logic [2:0]        block_id_reg, block_id_next;
  logic              block_valid_reg, block_valid_next;
  logic [63:0]       group_data_reg, group_data_next;
  logic              group_valid_reg, group_valid_next;

  logic [25:0] win;
  logic [9:0]  syn;
  logic        off_hit;
  logic [2:0]  off_id;
  logic [1:0]  off_slot;
  logic [4:0]  bad_inc;

  logic        emit_v, emit_good, lose_sync;
  logic [1:0]  emit_slot;
  logic [2:0]  emit_id;
  logic [15:0] emit_data;

  assign win      = {sr_reg[24:0], bit_in};
  assign syn      = crc10(win[25:10]) ^ win[9:0];
  assign off_slot = id_to_slot(off_id);
  assign bad_inc  = {1'b0, bad_count_reg} + 5'd1;

  always_comb begin
    off_hit = 1'b1;
    off_id  = 3'd0;
    case (syn)
      OFS_A:   off_id = 3'd0;
      OFS_B:   off_id = 3'd1;
      OFS_C:   off_id = 3'd2;
      OFS_CP:  off_id = 3'd3;
      OFS_D:   off_id = 3'd4;
      default: off_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_next       = state_reg;
    sr_next          = sr_reg;
    bitpos_next      = bitpos_reg;
    cand_id_next     = cand_id_reg;
    cand_data_next   = cand_data_reg;
    exp_slot_next    = exp_slot_reg;
    bad_count_next   = bad_count_reg;
    flags_next       = flags_reg;
    slot_next        = slot_reg;
    pend_valid_next  = 1'b0;
    pend_id_next     = pend_id_reg;
    pend_data_next   = pend_data_reg;
    block_data_next  = block_data_reg;
    block_id_next    = block_id_reg;
    block_valid_next = 1'b0;
    group_data_next  = group_data_reg;
    group_valid_next = 1'b0;
    emit_v    = 1'b0;
    emit_good = 1'b0;
    emit_slot = 2'd0;
    emit_id   = 3'd0;
    emit_data = 16'd0;
    lose_sync = 1'b0;

    // Confirming block of a fresh sync goes out one cycle after the candidate.
    if (pend_valid_reg) begin
      emit_v    = 1'b1;
      emit_good = 1'b1;
      emit_slot = id_to_slot(pend_id_reg);
      emit_id   = pend_id_reg;
      emit_data = pend_data_reg;
    end

    if (bit_valid) begin
      sr_next     = win;
      bitpos_next = (bitpos_reg == 5'd25) ? 5'd0 : bitpos_reg + 5'd1;
      case (state_reg)
        SEARCH: begin
          if (off_hit) begin
            cand_id_next   = off_id;
            cand_data_next = win[25:10];
            bitpos_next    = 5'd0;
            state_next     = CONFIRM;
          end
        end
        CONFIRM: begin
          if (bitpos_reg == 5'd25) begin
            if (off_hit && off_slot == id_to_slot(cand_id_reg) + 2'd1) begin
              state_next      = SYNC;
              emit_v          = 1'b1;
              emit_good       = 1'b1;
              emit_slot       = id_to_slot(cand_id_reg);
              emit_id         = cand_id_reg;
              emit_data       = cand_data_reg;
              pend_valid_next = 1'b1;
              pend_id_next    = off_id;
              pend_data_next  = win[25:10];
              exp_slot_next   = off_slot + 2'd1;
              bad_count_next  = 4'd0;
            end else if (off_hit) begin
              cand_id_next   = off_id;
              cand_data_next = win[25:10];
              bitpos_next    = 5'd0;
            end else begin
              state_next = SEARCH;
            end
          end
        end
        SYNC: begin
          if (bitpos_reg == 5'd25) begin
            exp_slot_next = exp_slot_reg + 2'd1;
            emit_v        = 1'b1;
            emit_slot     = exp_slot_reg;
            if (off_hit && off_slot == exp_slot_reg) begin
              emit_good      = 1'b1;
              emit_id        = off_id;
              emit_data      = win[25:10];
              bad_count_next = 4'd0;
            end else if (bad_inc >= 5'(c_max_bad)) begin
              state_next     = SEARCH;
              bad_count_next = 4'd0;
              lose_sync      = 1'b1;
            end else if (bad_count_reg != 4'hF) begin
              bad_count_next = bad_inc[3:0];
            end
          end
        end
        default: state_next = SEARCH;
      endcase
    end

    if (emit_v) begin
      if (emit_good) begin
        block_valid_next = 1'b1;
        block_data_next  = emit_data;
        block_id_next    = emit_id;
        if (emit_slot == 2'd0) flags_next = 4'b0001;
        else                   flags_next[emit_slot] = 1'b1;
        slot_next[emit_slot] = emit_data;
      end else begin
        flags_next[emit_slot] = 1'b0;
      end
      if (emit_slot == 2'd3 && flags_next == 4'hF) begin
        group_data_next  = {slot_next[0], slot_next[1], slot_next[2], slot_next[3]};
        group_valid_next = 1'b1;
      end
    end
    // A partial group must not survive a resync at a different slot.
    if (lose_sync) flags_next = 4'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= SEARCH;
      sr_reg          <= '0;
      bitpos_reg      <= '0;
      cand_id_reg     <= '0;
      cand_data_reg   <= '0;
      exp_slot_reg    <= '0;
      bad_count_reg   <= '0;
      flags_reg       <= '0;
      slot_reg        <= '0;
      pend_valid_reg  <= 1'b0;
      pend_id_reg     <= '0;
      pend_data_reg   <= '0;
      block_data_reg  <= '0;
      block_id_reg    <= '0;
      block_valid_reg <= 1'b0;
      group_data_reg  <= '0;
      group_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      sr_reg          <= sr_next;
      bitpos_reg      <= bitpos_next;
      cand_id_reg     <= cand_id_next;
      cand_data_reg   <= cand_data_next;
      exp_slot_reg    <= exp_slot_next;
      bad_count_reg   <= bad_count_next;
      flags_reg       <= flags_next;
      slot_reg        <= slot_next;
      pend_valid_reg  <= pend_valid_next;
      pend_id_reg     <= pend_id_next;
      pend_data_reg   <= pend_data_next;
      block_data_reg  <= block_data_next;
      block_id_reg    <= block_id_next;
      block_valid_reg <= block_valid_next;
      group_data_reg  <= group_data_next;
      group_valid_reg <= group_valid_next;
    end
  end

  assign block_data  = block_data_reg;
  assign block_id    = block_id_reg;
  assign block_valid = block_valid_reg;
  assign group_data  = group_data_reg;
  assign group_valid = group_valid_reg;
  assign synced      = (state_reg == SYNC);
  assign bad_count   = bad_count_reg;

endmodule

// File: tb/tb_rds_block_sync.sv
// Directed bench for rds_block_sync: sync acquisition, C' groups, flywheel,
// loss of sync and mid-block reset, with hand-computed expectations.
module tb_rds_block_sync;

  localparam logic [25:0] W_A  = 26'h00000FC;
  localparam logic [25:0] W_B  = 26'h0000198;
  localparam logic [25:0] W_C  = 26'h0000168;
  localparam logic [25:0] W_CP = 26'h0000350;
  localparam logic [25:0] W_D  = 26'h00001B4;
  // m=0x1234: crc(0x1234)=0x096, check = 0x096^0x198 = 0x10E
  localparam logic [25:0] W_B1234 = 26'h048D10E;

  logic        clk = 1'b0;
  logic        reset;
  logic        bit_in;
  logic        bit_valid;
  logic [15:0] block_data;
  logic [2:0]  block_id;
  logic        block_valid;
  logic [63:0] group_data;
  logic        group_valid;
  logic        synced;
  logic [3:0]  bad_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_strobe_cyc = 0;

  int          blk_id_q[$];
  int          blk_cyc_q[$];
  logic [15:0] blk_data_q[$];
  int          grp_cnt = 0;
  int          grp_cyc = 0;
  logic [63:0] grp_last = '0;

  rds_block_sync #(.c_max_bad(8)) dut (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .block_data(block_data), .block_id(block_id), .block_valid(block_valid),
    .group_data(group_data), .group_valid(group_valid),
    .synced(synced), .bad_count(bad_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (block_valid) begin
      blk_id_q.push_back(int'(block_id));
      blk_cyc_q.push_back(cyc);
      blk_data_q.push_back(block_data);
      $display("block id=%0d data=%h cyc=%0d", block_id, block_data, cyc);
    end
    if (group_valid) begin
      grp_cnt++;
      grp_cyc  = cyc;
      grp_last = group_data;
      $display("group data=%h cyc=%0d", group_data, cyc);
    end
  end

  initial begin
    #1ms;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] ids_packed();
    logic [31:0] v = '0;
    foreach (blk_id_q[i]) v = (v << 4) | 32'(blk_id_q[i]);
    return v;
  endfunction

  task automatic clear_mon();
    blk_id_q.delete();
    blk_cyc_q.delete();
    blk_data_q.delete();
    grp_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends w[n-1:0] MSB first, with 'gap' idle cycles after each strobe.
  task automatic send_bits(input logic [25:0] w, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      bit_in    = w[i];
      bit_valid = 1'b1;
      @(posedge clk);
      #1;
      last_strobe_cyc = cyc;
      bit_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bit_valid = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    checks++;
    if ({block_valid, group_valid, synced, bad_count, block_id} !== 10'd0 ||
        block_data !== 16'd0 || group_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_outputs actual=%b/%h/%h required=0/0/0",
               {block_valid, group_valid, synced, bad_count, block_id}, block_data, group_data);
    end
  endtask

  task automatic test_basic_groups();
    int sb, sd;
    clear_mon();
    send_bits(W_A, 26, 0);
    idle(2);
    checks++;
    if (synced !== 1'b0 || blk_id_q.size() != 0) begin
      errors++;
      $display("FAIL basic_after_a synced=%b blocks=%0d required synced=0 blocks=0", synced, blk_id_q.size());
    end
    send_bits(W_B, 26, 0);
    sb = last_strobe_cyc;
    idle(2);
    checks++;
    if (synced !== 1'b1) begin
      errors++;
      $display("FAIL basic_synced actual=%b required=1", synced);
    end
    checks++;
    if (blk_id_q.size() != 2 || ids_packed() !== 32'h01) begin
      errors++;
      $display("FAIL basic_confirm_ids actual=%h n=%0d required=01 n=2", ids_packed(), blk_id_q.size());
    end
    checks++;
    if (blk_cyc_q.size() != 2 || blk_cyc_q[0] != sb || blk_cyc_q[1] != sb + 1) begin
      errors++;
      $display("FAIL basic_confirm_timing actual=%p required=%0d,%0d", blk_cyc_q, sb, sb + 1);
    end
    send_bits(W_C, 26, 0);
    send_bits(W_D, 26, 0);
    idle(2);
    // The confirmed A and B fill their slots, so the first D already completes a group.
    checks++;
    if (blk_id_q.size() != 4 || ids_packed() !== 32'h0124 || grp_cnt != 1) begin
      errors++;
      $display("FAIL basic_group1 ids=%h groups=%0d required ids=0124 groups=1", ids_packed(), grp_cnt);
    end
    clear_mon();
    send_bits(W_A, 26, 0);
    send_bits(W_B, 26, 0);
    send_bits(W_C, 26, 0);
    send_bits(W_D, 26, 0);
    sd = last_strobe_cyc;
    idle(2);
    checks++;
    if (blk_id_q.size() != 4 || ids_packed() !== 32'h0124) begin
      errors++;
      $display("FAIL basic_ids2 actual=%h required=0124", ids_packed());
    end
    checks++;
    if (grp_cnt != 1 || grp_last !== 64'd0 || grp_cyc != sd) begin
      errors++;
      $display("FAIL basic_group2 cnt=%0d data=%h cyc=%0d required cnt=1 data=0 cyc=%0d",
               grp_cnt, grp_last, grp_cyc, sd);
    end
  endtask

  task automatic test_noise_then_sync();
    int sb;
    pulse_reset();
    clear_mon();
    send_bits(26'b1000000000001, 13, 0);
    send_bits(W_A, 26, 0);
    idle(1);
    checks++;
    if (synced !== 1'b0 || blk_id_q.size() != 0 || grp_cnt != 0) begin
      errors++;
      $display("FAIL noise_no_early_sync synced=%b blocks=%0d groups=%0d required 0/0/0",
               synced, blk_id_q.size(), grp_cnt);
    end
    send_bits(W_B, 26, 0);
    sb = last_strobe_cyc;
    idle(2);
    checks++;
    if (synced !== 1'b1 || blk_cyc_q.size() != 2 || blk_cyc_q[0] != sb || ids_packed() !== 32'h01) begin
      errors++;
      $display("FAIL noise_boundary synced=%b ids=%h cyc=%p required synced=1 ids=01 first=%0d",
               synced, ids_packed(), blk_cyc_q, sb);
    end
    send_bits(W_C, 26, 0);
    idle(1);
    checks++;
    if (grp_cnt != 0) begin
      errors++;
      $display("FAIL noise_false_group actual=%0d required=0", grp_cnt);
    end
    send_bits(W_D, 26, 0);
    idle(2);
    checks++;
    if (grp_cnt != 1 || ids_packed() !== 32'h0124) begin
      errors++;
      $display("FAIL noise_group groups=%0d ids=%h required groups=1 ids=0124", grp_cnt, ids_packed());
    end
  endtask

  task automatic test_c_prime();
    clear_mon();
    send_bits(W_A, 26, 0);
    send_bits(W_B1234, 26, 1);
    send_bits(W_CP, 26, 0);
    send_bits(W_D, 26, 0);
    idle(2);
    checks++;
    if (blk_id_q.size() != 4 || ids_packed() !== 32'h0134) begin
      errors++;
      $display("FAIL cprime_ids actual=%h required=0134", ids_packed());
    end
    checks++;
    if (blk_data_q.size() < 2 || blk_data_q[1] !== 16'h1234) begin
      errors++;
      $display("FAIL cprime_b_data actual=%p required=1234 at index 1", blk_data_q);
    end
    checks++;
    if (grp_cnt != 1 || grp_last !== 64'h0000_1234_0000_0000) begin
      errors++;
      $display("FAIL cprime_group cnt=%0d data=%h required cnt=1 data=0000123400000000", grp_cnt, grp_last);
    end
  endtask

  task automatic test_corrupt_b();
    clear_mon();
    send_bits(W_A, 26, 0);
    send_bits(W_B ^ 26'h1, 26, 0);
    idle(2);
    checks++;
    if (bad_count !== 4'd1 || synced !== 1'b1) begin
      errors++;
      $display("FAIL corrupt_bad1 bad_count=%0d synced=%b required 1/1", bad_count, synced);
    end
    send_bits(W_C, 26, 0);
    idle(2);
    checks++;
    if (bad_count !== 4'd0 || synced !== 1'b1) begin
      errors++;
      $display("FAIL corrupt_recover bad_count=%0d synced=%b required 0/1", bad_count, synced);
    end
    send_bits(W_D, 26, 0);
    idle(2);
    checks++;
    if (grp_cnt != 0 || ids_packed() !== 32'h024 || synced !== 1'b1) begin
      errors++;
      $display("FAIL corrupt_group groups=%0d ids=%h synced=%b required 0/024/1", grp_cnt, ids_packed(), synced);
    end
  endtask

  task automatic test_loss_of_sync();
    clear_mon();
    repeat (7) send_bits(26'd0, 26, 0);
    idle(1);
    checks++;
    if (bad_count !== 4'd7 || synced !== 1'b1) begin
      errors++;
      $display("FAIL los_seven bad_count=%0d synced=%b required 7/1", bad_count, synced);
    end
    send_bits(26'd0, 25, 0);
    checks++;
    if (synced !== 1'b1) begin
      errors++;
      $display("FAIL los_before_boundary synced=%b required=1", synced);
    end
    send_bits(26'd0, 1, 0);
    checks++;
    if (synced !== 1'b0 || bad_count !== 4'd0) begin
      errors++;
      $display("FAIL los_drop synced=%b bad_count=%0d required 0/0", synced, bad_count);
    end
    checks++;
    if (blk_id_q.size() != 0 || grp_cnt != 0) begin
      errors++;
      $display("FAIL los_no_pulses blocks=%0d groups=%0d required 0/0", blk_id_q.size(), grp_cnt);
    end
  endtask

  task automatic test_reset_mid_block();
    clear_mon();
    send_bits(W_A, 26, 0);
    send_bits(W_B1234, 26, 0);
    idle(2);
    checks++;
    if (synced !== 1'b1 || block_data !== 16'h1234 || block_id !== 3'd1) begin
      errors++;
      $display("FAIL midrst_pre synced=%b data=%h id=%0d required 1/1234/1", synced, block_data, block_id);
    end
    send_bits(W_C >> 16, 10, 0);
    pulse_reset();
    checks++;
    if ({block_valid, group_valid, synced, bad_count, block_id} !== 10'd0 ||
        block_data !== 16'd0 || group_data !== 64'd0) begin
      errors++;
      $display("FAIL midrst_outputs actual=%b/%h/%h required=0/0/0",
               {block_valid, group_valid, synced, bad_count, block_id}, block_data, group_data);
    end
    clear_mon();
    send_bits(W_A, 26, 0);
    send_bits(W_B, 26, 0);
    idle(2);
    checks++;
    if (synced !== 1'b1 || ids_packed() !== 32'h01 || blk_id_q.size() != 2) begin
      errors++;
      $display("FAIL midrst_resync synced=%b ids=%h required 1/01", synced, ids_packed());
    end
  endtask

  initial begin
    reset     = 1'b1;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    idle(3);
    test_reset();
    test_basic_groups();
    test_noise_then_sync();
    test_c_prime();
    test_corrupt_b();
    test_loss_of_sync();
    test_reset_mid_block();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rds_block_sync.md
# rds_block_sync

Receive-side RDS block synchroniser and group assembler: the counterpart of the RDS transmit path that turns the circular message into the 57 kHz subcarrier. It takes the demodulated, differentially decoded RDS bitstream (1187.5 bit/s strobes from the upstream bit recovery), finds 26-bit block boundaries by checkword/offset matching, and tracks sync. It emits checked 16-bit blocks and complete A-B-C-D groups for the message store or CPU.

## Interface
- c_max_bad, default 8: consecutive bad blocks in SYNC that force a return to SEARCH (range 1..15).
- clk  in  1  system clock (25 MHz domain).
- reset  in  1  synchronous, active-high reset.
- bit_in  in  1  received RDS data bit, MSB of each block first.
- bit_valid  in  1  one-cycle strobe; bit_in is sampled when high. Back-to-back strobes are legal.
- block_data  out  16  information word of the last good block.
- block_id  out  3  offset of the last good block: 0=A, 1=B, 2=C, 3=C', 4=D.
- block_valid  out  1  one-cycle pulse when block_data/block_id update.
- group_data  out  64  {A,B,C|C',D} information words of the last complete group.
- group_valid  out  1  one-cycle pulse when group_data updates.
- synced  out  1  high while in SYNC state.
- bad_count  out  4  current consecutive-bad-block count, saturating at 15.

## Operation
- Shift register sr[25:0]. On bit_valid: sr <= {sr[24:0], bit_in}. sr[25:10] is the info word m, sr[9:0] is the received check c.
- Checkword: crc(m) = remainder of m(x)·x^10 mod g(x), with g(x)=x^10+x^8+x^7+x^5+x^4+x^3+1 (0x5B9). It is evaluated combinationally on the updated window.
- Offset syndrome s = crc(m) XOR c. The offsets are A=0x0FC, B=0x198, C=0x168, C'=0x350, D=0x1B4. Any other value is a bad block.
- bit counter bitpos 0..25 counts strobes since the last block boundary.
- States:
  - SEARCH: each strobe, if s matches any offset, record it as cand, set bitpos=0, and go to CONFIRM. No outputs are emitted.
  - CONFIRM: at the 26th strobe after the candidate, compare s to expected = next(cand), where next is A→B, B→C/C', C/C'→D, D→A.
    - Match: go to SYNC and emit both the candidate and the current block via group logic, in order, with one block_valid per cycle; the candidate block is emitted first. Set bad_count=0.
    - Mismatch: go back to SEARCH, but re-test the current window as a new candidate in the same cycle.
  - SYNC: evaluate only at bitpos wrap (every 26 strobes).
    - Position C accepts C or C'.
    - A good block emits block_valid and clears bad_count.
    - A bad block increments bad_count. Expected still advances, so the flywheel keeps block position.
    - If bad_count reaches c_max_bad, go to SEARCH and set bad_count=0.
- Group assembly: slots A,B,C,D each have a good flag. An A block clears all flags and then fills slot A. At slot D evaluation, if all four flags are set, group_data is loaded and group_valid pulses. A bad block clears its slot flag.
- The SYNC-state block_id reflects the expected position; C' is reported as 3.

## Timing
- All outputs are registered. block_valid and group_valid assert exactly 1 cycle after the bit_valid cycle that completed the block.
- In the CONFIRM→SYNC transition, the candidate block pulses at +1 and the confirming block at +2. group_valid is only possible from +2.
- Reset values: block_data=0, block_id=0, block_valid=0, group_data=0, group_valid=0, synced=0, bad_count=0, sr=0, bitpos=0, state=SEARCH, all slot flags clear.
- Reset wins over a simultaneous bit_valid. Reset mid-block discards the partial block and the group.
- With bit_valid low, all state holds and no pulse is generated.
- bitpos wraps 25→0 on the boundary strobe.

## Test plan
- Reset, then feed the four 26-bit words 0x00000FC, 0x0000198, 0x0000168, 0x00001B4 MSB-first, and repeat once. Required: synced=1 after word 2; block_valid pulses with ids 0,1,2,4,…; group_valid=1 with group_data=0 on the 2nd D.
- Feed 13 random bits, then the same group sequence. Required: sync is acquired at the correct boundary, with no false group_valid before the first full A..D.
- Feed a group with C' (0x0000350 as word 3) and m=0x1234 in block B (checkword crc(0x1234) XOR 0x198). Required: block_id=3 at position C, group_data[47:32]=0x1234.
- While in SYNC, corrupt 1 bit of block B. Required: no group_valid for that group, bad_count=1 then 0 on the next good block, synced stays 1.
- While in SYNC, send c_max_bad (8) consecutive all-zero words. Required: synced drops 1 cycle after the 8th boundary strobe, bad_count=0.
- Assert reset for 1 cycle in the middle of block C. Required: all outputs return to reset values next cycle, and resync on fresh A,B.
